// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, frame constants and the parity helper.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

   localparam int unsigned UART_DATA_BITS = 8;
   localparam logic        LINE_IDLE      = 1'b1;
   localparam logic        START_BIT      = 1'b0;
   localparam logic        STOP_BIT       = 1'b1;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      TX_PARITY = 3'd3,
`endif
      TX_STOP   = 3'd4
   } tx_state_e;

   function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO. A push is refused whenever the registered full flag is set,
// even when a pop happens on the same edge.
module uart_tx_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       wdata_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       rdata_c_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             full_q;
   logic             empty_q;
   logic             push_ok;
   logic             pop_ok;

   always_comb begin
      push_ok = push_i && !full_q;
      pop_ok  = pop_i && !empty_q;
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
   end

   // Pointers wrap naturally; flags are registered from the next count.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
         full_q  <= (count_d == CNT_W'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_c_o = mem_q[rd_ptr_q];
   assign full_o    = full_q;
   assign empty_o   = empty_q;
   assign count_o   = count_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed 8N1/8N2 framer, even parity with UART_TX_PARITY_EN.
// Line outputs are registered from the current state, so the line trails the FSM by one clock.
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 217,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                        i_Clock,
   input  logic                        i_Rst,
   input  logic                        i_TX_DV,
   input  logic [7:0]                  i_TX_Byte,
   output logic                        o_TX_Ready,
   output logic                        o_TX_Serial,
   output logic                        o_TX_Active,
   output logic                        o_TX_Done,
   output logic [$clog2(FIFO_DEPTH):0] o_FIFO_Count
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W = 3;

   tx_state_e                   state_q;
   tx_state_e                   state_d;
   logic [CNT_W-1:0]            clk_cnt_q;
   logic [CNT_W-1:0]            clk_cnt_d;
   logic [IDX_W-1:0]            bit_idx_q;
   logic [IDX_W-1:0]            bit_idx_d;
   logic [UART_DATA_BITS-1:0]   data_q;
   logic [UART_DATA_BITS-1:0]   data_d;
   logic                        serial_q;
   logic                        serial_d;
   logic                        active_q;
   logic                        active_d;
   logic                        done_q;
   logic                        done_d;
   logic                        pop_c;
   logic                        last_clk_c;
   logic [UART_DATA_BITS-1:0]   fifo_head;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_fifo (
      .clk_i     (i_Clock),
      .rst_i     (i_Rst),
      .push_i    (i_TX_DV),
      .wdata_i   (i_TX_Byte),
      .pop_i     (pop_c),
      .rdata_c_o (fifo_head),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .count_o   (fifo_count)
   );

   assign last_clk_c = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

   always_ff @(posedge i_Clock) begin
      if (i_Rst) begin
         state_q   <= TX_IDLE;
         clk_cnt_q <= '0;
         bit_idx_q <= '0;
         data_q    <= '0;
         serial_q  <= LINE_IDLE;
         active_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_idx_q <= bit_idx_d;
         data_q    <= data_d;
         serial_q  <= serial_d;
         active_q  <= active_d;
         done_q    <= done_d;
      end
   end

   // bit_idx_q counts data bits in DATA and stop bits in STOP.
   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_idx_d = bit_idx_q;
      data_d    = data_q;
      pop_c     = 1'b0;
      serial_d  = LINE_IDLE;
      active_d  = 1'b0;
      done_d    = 1'b0;
      unique case (state_q)
         TX_IDLE: begin
            if (!fifo_empty) begin
               pop_c     = 1'b1;
               data_d    = fifo_head;
               clk_cnt_d = '0;
               bit_idx_d = '0;
               state_d   = TX_START;
            end
         end
         TX_START: begin
            serial_d = START_BIT;
            active_d = 1'b1;
            if (last_clk_c) begin
               clk_cnt_d = '0;
               state_d   = TX_DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
         TX_DATA: begin
            serial_d = data_q[bit_idx_q];
            active_d = 1'b1;
            if (last_clk_c) begin
               clk_cnt_d = '0;
               if (bit_idx_q == IDX_W'(UART_DATA_BITS - 1)) begin
                  bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d   = TX_PARITY;
`else
                  state_d   = TX_STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + IDX_W'(1);
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
`ifdef UART_TX_PARITY_EN
         TX_PARITY: begin
            serial_d = even_parity(data_q);
            active_d = 1'b1;
            if (last_clk_c) begin
               clk_cnt_d = '0;
               state_d   = TX_STOP;
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
`endif
         TX_STOP: begin
            serial_d = STOP_BIT;
            active_d = 1'b1;
            if (last_clk_c) begin
               clk_cnt_d = '0;
               if (bit_idx_q == IDX_W'(STOP_BITS - 1)) begin
                  done_d    = 1'b1;
                  bit_idx_d = '0;
                  if (!fifo_empty) begin
                     pop_c   = 1'b1;
                     data_d  = fifo_head;
                     state_d = TX_START;
                  end else begin
                     state_d = TX_IDLE;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + IDX_W'(1);
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

   assign o_TX_Ready   = !fifo_full;
   assign o_TX_Serial  = serial_q;
   assign o_TX_Active  = active_q;
   assign o_TX_Done    = done_q;
   assign o_FIFO_Count = fifo_count;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: a 1-stop and a 2-stop instance share one stimulus stream and are
// checked every clock against a frame-schedule model (start time of each accepted byte).
module tb_uart_tx_buffered;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int NF    = 256;
`ifdef UART_TX_PARITY_EN
   localparam int PAR   = 1;
`else
   localparam int PAR   = 0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       dv;
   logic [7:0] tx_byte;
   logic [1:0] ready, serial, active, done;
   logic [2:0] fcnt [2];

   always #5 clk = ~clk;

   uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut1 (
      .i_Clock(clk), .i_Rst(rst), .i_TX_DV(dv), .i_TX_Byte(tx_byte),
      .o_TX_Ready(ready[0]), .o_TX_Serial(serial[0]), .o_TX_Active(active[0]),
      .o_TX_Done(done[0]), .o_FIFO_Count(fcnt[0]));

   uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut2 (
      .i_Clock(clk), .i_Rst(rst), .i_TX_DV(dv), .i_TX_Byte(tx_byte),
      .o_TX_Ready(ready[1]), .o_TX_Serial(serial[1]), .o_TX_Active(active[1]),
      .o_TX_Done(done[1]), .o_FIFO_Count(fcnt[1]));

   // Frame schedule per instance: accept edge, first start-bit cycle, byte.
   int         nfr [2];
   int         acc_t [2][NF];
   int         st_t [2][NF];
   logic [7:0] fr_byte [2][NF];
   int         cyc;
   int         n_cmp;
   int         n_err;
   int         act_cnt;
   int         done_cnt;

   function automatic int flen(input int i);
      return (10 + i + PAR) * CPB;
   endfunction

   function automatic int m_count(input int i, input int c);
      int n;
      n = 0;
      for (int k = 0; k < nfr[i]; k++)
         if (acc_t[i][k] <= c && st_t[i][k] - 1 > c) n++;
      return n;
   endfunction

   function automatic logic frame_bit(input logic [7:0] b, input int j);
      if (j == 0) return 1'b0;
      if (j <= 8) return b[3'(j - 1)];
      if (PAR == 1 && j == 9) return ^b;
      return 1'b1;
   endfunction

   function automatic logic m_serial(input int i, input int c);
      for (int k = 0; k < nfr[i]; k++)
         if (c >= st_t[i][k] && c < st_t[i][k] + flen(i))
            return frame_bit(fr_byte[i][k], (c - st_t[i][k]) / CPB);
      return 1'b1;
   endfunction

   function automatic logic m_active(input int i, input int c);
      for (int k = 0; k < nfr[i]; k++)
         if (c >= st_t[i][k] && c < st_t[i][k] + flen(i)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic m_done(input int i, input int c);
      for (int k = 0; k < nfr[i]; k++)
         if (c == st_t[i][k] + flen(i) - 1) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check(input string tag, input int i, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, i + 1, cyc, obs, exp);
      end
   endtask

   // One clock: drive inputs, update the model on the edge, then check both instances.
   task automatic step(input logic r, input logic v, input logic [7:0] b, output bit a0);
      bit acc [2];
      int prev;
      int s;
      rst = r;
      dv = v;
      tx_byte = b;
      for (int i = 0; i < 2; i++) acc[i] = !r && v && (m_count(i, cyc) < DEPTH);
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (r) begin
            nfr[i] = 0;
         end else if (acc[i]) begin
            if (nfr[i] >= NF) begin
               $display("FAIL model_capacity dut%0d cyc=%0d frames=%0d limit=%0d", i + 1, cyc, nfr[i], NF);
               $fatal(1, "frame table overflow");
            end
            prev = (nfr[i] > 0) ? st_t[i][nfr[i] - 1] + flen(i) : -1000000;
            s = (prev > cyc + 2) ? prev : cyc + 2;
            acc_t[i][nfr[i]] = cyc;
            st_t[i][nfr[i]] = s;
            fr_byte[i][nfr[i]] = b;
            nfr[i]++;
         end
      end
      #1;
      for (int i = 0; i < 2; i++) begin
         check("ready",  i, 8'(ready[i]),  8'(m_count(i, cyc) < DEPTH));
         check("serial", i, 8'(serial[i]), 8'(m_serial(i, cyc)));
         check("active", i, 8'(active[i]), 8'(m_active(i, cyc)));
         check("done",   i, 8'(done[i]),   8'(m_done(i, cyc)));
         check("count",  i, 8'(fcnt[i]),   8'(m_count(i, cyc)));
      end
      if (active[0] === 1'b1) act_cnt++;
      if (done[0] === 1'b1) done_cnt++;
      a0 = acc[0];
   endtask

   initial begin
      bit         a0;
      int         n0;
      int         idx;
      int         nb;
      int         t;
      logic [9:0] bits;
      logic [9:0] exp_bits;
      logic       r;
      logic       v;
      int         burst;

      rst = 1'b1; dv = 1'b0; tx_byte = 8'h00;
      cyc = 0; n_cmp = 0; n_err = 0; act_cnt = 0; done_cnt = 0;
      nfr[0] = 0; nfr[1] = 0;

      // Reset state
      step(1'b1, 1'b0, 8'h00, a0);
      step(1'b1, 1'b0, 8'h00, a0);
      step(1'b0, 1'b0, 8'h00, a0);

      // Single byte 0xA5: mid-bit line samples, active length, one done pulse
      act_cnt = 0; done_cnt = 0; idx = 0; bits = '0;
      step(1'b0, 1'b1, 8'hA5, a0);
      n0 = cyc;
      for (int k = 0; k < 60; k++) begin
         step(1'b0, 1'b0, 8'h00, a0);
         if (cyc >= n0 + 2 && ((cyc - n0 - 2) % CPB) == CPB / 2 && idx < 10) begin
            bits[idx] = serial[0];
            idx++;
         end
      end
      exp_bits = (PAR == 1) ? 10'b0101001010 : 10'b1101001010;
      check("a5_first_accept", 0, 8'(a0 | (n0 > 0)), 8'd1);
      check("a5_bits_lo", 0, bits[7:0], exp_bits[7:0]);
      check("a5_bits_hi", 0, 8'(bits[9:8]), 8'(exp_bits[9:8]));
      check("a5_active_clks", 0, 8'(act_cnt), 8'(flen(0)));
      check("a5_done_pulses", 0, 8'(done_cnt), 8'd1);

      // Hold DV with 0x01..0x06: back-to-back frames
      act_cnt = 0; done_cnt = 0; nb = 1; t = 0;
      while (nb <= 6 && t < 100) begin
         step(1'b0, 1'b1, 8'(nb), a0);
         if (a0) nb++;
         t++;
      end
      check("burst_all_pushed", 0, 8'(nb), 8'd7);
      for (int k = 0; k < 300; k++) step(1'b0, 1'b0, 8'h00, a0);
      check("burst_active_clks", 0, 8'(act_cnt), 8'(6 * flen(0)));
      check("burst_done_pulses", 0, 8'(done_cnt), 8'd6);

      // Reset mid-DATA with two bytes queued: nothing more is sent
      for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 8'($urandom), a0);
      for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 8'h00, a0);
      check("pre_reset_count", 0, 8'(fcnt[0]), 8'd2);
      step(1'b1, 1'b0, 8'h00, a0);
      act_cnt = 0;
      for (int k = 0; k < 80; k++) step(1'b0, 1'b0, 8'h00, a0);
      check("post_reset_active", 0, 8'(act_cnt), 8'd0);

      // 0x00 then 0xFF (exercises the two-stop instance's long high run)
      step(1'b0, 1'b1, 8'h00, a0);
      step(1'b0, 1'b1, 8'hFF, a0);
      for (int k = 0; k < 120; k++) step(1'b0, 1'b0, 8'h00, a0);

      // Randomised bursts, gaps and occasional resets
      burst = 0;
      for (int k = 0; k < 2500; k++) begin
         if (burst == 0) burst = $urandom_range(1, 40);
         burst--;
         r = ($urandom_range(0, 599) == 0);
         v = (k / 200) % 2 == 0 ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
         step(r, v, 8'($urandom), a0);
      end
      for (int k = 0; k < 300; k++) step(1'b0, 1'b0, 8'h00, a0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
